pipe_hazard_ctrl: RTL

- Central sequencer for the five pipeline registers (regF/regD/regE/regM/regW) of the rv32 pipeline CPU.
- Computes per-stage stall and bubble controls from three sources: load-use hazards, branch mispredicts resolved in E, and multi-cycle data-memory handshakes in M.
- Tracks halt (ebreak committed at W) and keeps commit and stall counters for the difftest/commit path.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_if.sv | 61 ++++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// register-index width and the x0 index, which never carries a dependency.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives hazard sources and reads stage controls
//   slave  : controller side, reads hazard sources and drives stage controls
// Signals:
//   d_rs1/d_rs2, d_rs1_used/d_rs2_used : source operands of the D instruction
//   e_mem_rd, e_rd, e_mispredict       : load flag, destination, redirect of E
//   m_mem_req, dmem_ready              : data-memory handshake in M
//   w_commit, w_halt                   : commit/ebreak at W
//   f/d/e/m_stall, d/e/w_bubble        : per-stage hold / NOP-insert controls
//   dmem_req_valid, cpu_halted         : memory request strobe, halt status
//   commit_cnt, stall_cnt              : wrap-around statistics counters
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic [REG_IDX_W-1:0] d_rs1;
    logic [REG_IDX_W-1:0] d_rs2;
    logic                 d_rs1_used;
    logic                 d_rs2_used;
    logic                 e_mem_rd;
    logic [REG_IDX_W-1:0] e_rd;
    logic                 e_mispredict;
    logic                 m_mem_req;
    logic                 dmem_ready;
    logic                 w_commit;
    logic                 w_halt;

    logic                 f_stall;
    logic                 d_stall;
    logic                 d_bubble;
    logic                 e_stall;
    logic                 e_bubble;
    logic                 m_stall;
    logic                 w_bubble;
    logic                 dmem_req_valid;
    logic                 cpu_halted;
    logic [CNT_W-1:0]     commit_cnt;
    logic [CNT_W-1:0]     stall_cnt;

    modport master (
        output d_rs1, d_rs2, d_rs1_used, d_rs2_used,
        output e_mem_rd, e_rd, e_mispredict,
        output m_mem_req, dmem_ready, w_commit, w_halt,
        input  f_stall, d_stall, d_bubble, e_stall, e_bubble, m_stall, w_bubble,
        input  dmem_req_valid, cpu_halted, commit_cnt, stall_cnt
    );

    modport slave (
        input  d_rs1, d_rs2, d_rs1_used, d_rs2_used,
        input  e_mem_rd, e_rd, e_mispredict,
        input  m_mem_req, dmem_ready, w_commit, w_halt,
        output f_stall, d_stall, d_bubble, e_stall, e_bubble, m_stall, w_bubble,
        output dmem_req_valid, cpu_halted, commit_cnt, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_hazard_detect
// Purely combinational load-use comparator: flags when the instruction in D
// reads a register that the load currently in E has not yet produced.
// Ports:
//   i_d_rs1/i_d_rs2, i_d_rs1_used/i_d_rs2_used : D source operands
//   i_e_mem_rd, i_e_rd                         : E is a load, and its target
//   o_load_use                                 : raw load-use hazard
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_d_rs1,
    input  logic [REG_IDX_W-1:0] i_d_rs2,
    input  logic                 i_d_rs1_used,
    input  logic                 i_d_rs2_used,
    input  logic                 i_e_mem_rd,
    input  logic [REG_IDX_W-1:0] i_e_rd,
    output logic                 o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_d_rs1_used && (i_d_rs1 == i_e_rd);
    assign w_rs2_hit = i_d_rs2_used && (i_d_rs2 == i_e_rd);

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign o_load_use = i_e_mem_rd && (i_e_rd != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central sequencer for regF/regD/regE/regM/regW. Produces per-stage stall and
// bubble controls from memory-wait, mispredict and load-use hazards (priority
// halt > memory wait > mispredict > load-use), tracks ebreak halt and keeps
// commit / memory-stall counters.
// Ports:
//   clk   : core clock
//   rst_n : synchronous active-low reset
//   bus   : pipe_hazard_ctrl_if.slave (hazard sources in, stage controls out)
// Stage controls are combinational and sampled by the pipeline registers on
// the same edge.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_commit_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_halted;
    logic w_req_valid;
    logic w_mstall;
    logic w_hold_all;
    logic w_load_use;
    logic w_misp_act;
    logic w_lu_act;
    logic w_halt_commit;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .i_d_rs1      (bus.d_rs1),
        .i_d_rs2      (bus.d_rs2),
        .i_d_rs1_used (bus.d_rs1_used),
        .i_d_rs2_used (bus.d_rs2_used),
        .i_e_mem_rd   (bus.e_mem_rd),
        .i_e_rd       (bus.e_rd),
        .o_load_use   (w_load_use)
    );

    // -------------------------------------------------------------------------
    // Hazard resolution
    // -------------------------------------------------------------------------
    assign w_halted      = (r_state == ST_HALTED);
    assign w_halt_commit = bus.w_commit && bus.w_halt;

    // The request simply follows M; since M is frozen while the request is
    // outstanding, it is held until dmem_ready is seen.
    assign w_req_valid = rst_n && !w_halted && bus.m_mem_req;
    assign w_mstall    = w_req_valid && !bus.dmem_ready;

    // Halted and memory-wait freeze the whole pipe identically.
    assign w_hold_all = rst_n && (w_halted || w_mstall);

    // A mispredict seen during a freeze persists because E is held, so it is
    // acted on once the freeze lifts. It outranks load-use since D is wrong-path.
    assign w_misp_act = rst_n && !w_hold_all && bus.e_mispredict;
    assign w_lu_act   = rst_n && !w_hold_all && !bus.e_mispredict && w_load_use;

    assign bus.f_stall        = w_hold_all || w_lu_act;
    assign bus.d_stall        = w_hold_all || w_lu_act;
    assign bus.d_bubble       = w_misp_act;
    assign bus.e_stall        = w_hold_all;
    assign bus.e_bubble       = w_misp_act || w_lu_act;
    assign bus.m_stall        = w_hold_all;
    assign bus.w_bubble       = w_hold_all;
    assign bus.dmem_req_valid = w_req_valid;
    assign bus.cpu_halted     = rst_n && w_halted;
    assign bus.commit_cnt     = r_commit_cnt;
    assign bus.stall_cnt      = r_stall_cnt;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    // NOTE: reset is sampled only on the clock edge (synchronous), so it lives
    // inside the clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default first, so every path assigns and no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (w_halt_commit) begin
                    w_next_state = ST_HALTED;
                end else if (bus.m_mem_req && !bus.dmem_ready) begin
                    w_next_state = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (w_halt_commit) begin
                    w_next_state = ST_HALTED;
                end else if (bus.dmem_ready) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_HALTED: begin
                w_next_state = ST_HALTED;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Counters (wrap modulo 2^CNT_W); the halting instruction is itself counted.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_commit_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (bus.w_commit && !w_halted) begin
                r_commit_cnt <= r_commit_cnt + CNT_W'(1);
            end
            if (w_mstall) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
